// File: rtl/sprite_compositor.sv
// Sprite compositor: per-sprite movement and hit test in sprite_lane, with a two-stage pix_en pipeline for ROM addressing and priority compositing.
// Optional collision detection is built only when SPRITE_COLLISION_EN is defined.
module sprite_lane #(
    parameter int LANE        = 0,
    parameter int SPRITE_SIZE = 64,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int STEP        = 3,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_end_i,
    input  logic              pix_en_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    input  logic              up_i,
    input  logic              down_i,
    input  logic              left_i,
    input  logic              right_i,
    input  logic              vis_i,
    output logic [9:0]        pos_x_o,
    output logic [9:0]        pos_y_o,
    output logic              hit_o,
    output logic [ADDR_W-1:0] addr_o
);
    localparam int          HALF   = ADDR_W / 2;
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);
    localparam logic [10:0] MAX_X  = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - SPRITE_SIZE);

    logic [9:0]        pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [10:0]       x11, y11, px11, py11;

    // Opposing requests cancel; moves saturate at both screen edges.
    function automatic logic [9:0] step_axis(input logic [9:0] p, input logic dec,
                                             input logic inc, input logic [10:0] maxv);
        logic [10:0] w;
        w = {1'b0, p};
        if (inc && !dec)
            w = (w + STEP11 > maxv) ? maxv : w + STEP11;
        else if (dec && !inc)
            w = (w >= STEP11) ? w - STEP11 : 11'd0;
        return 10'(w);
    endfunction

    always_comb begin
        x11     = {1'b0, x_i};
        y11     = {1'b0, y_i};
        px11    = {1'b0, pos_x_q};
        py11    = {1'b0, pos_y_q};
        pos_x_d = step_axis(pos_x_q, left_i, right_i, MAX_X);
        pos_y_d = step_axis(pos_y_q, up_i, down_i, MAX_Y);
        hit_d   = vis_i && (x11 >= px11) && (x11 < px11 + SIZE11)
                        && (y11 >= py11) && (y11 < py11 + SIZE11);
        addr_d  = hit_d ? {HALF'(y11 - py11), HALF'(x11 - px11)} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q <= 10'(LANE * SPRITE_SIZE);
            pos_y_q <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            if (frame_end_i) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
            end
            if (pix_en_i) begin
                hit_q  <= hit_d;
                addr_q <= addr_d;
            end
        end
    end

    assign pos_x_o = pos_x_q;
    assign pos_y_o = pos_y_q;
    assign hit_o   = hit_q;
    assign addr_o  = addr_q;
endmodule

module sprite_compositor #(
    parameter int                 NUM_SPRITES     = 2,
    parameter int                 SPRITE_SIZE     = 64,
    parameter int                 SCREEN_W        = 640,
    parameter int                 SCREEN_H        = 480,
    parameter int                 STEP            = 3,
    parameter int                 COLOR_W         = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT_KEY = 12'hF0F
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  pix_en,
    input  logic                                                  active,
    input  logic                                                  frame_end,
    input  logic [9:0]                                            x,
    input  logic [9:0]                                            y,
    input  logic [NUM_SPRITES-1:0]                                mv_up,
    input  logic [NUM_SPRITES-1:0]                                mv_down,
    input  logic [NUM_SPRITES-1:0]                                mv_left,
    input  logic [NUM_SPRITES-1:0]                                mv_right,
    input  logic [NUM_SPRITES-1:0]                                spr_vis,
    output logic [NUM_SPRITES*2*$clog2(SPRITE_SIZE)-1:0]          spr_addr,
    input  logic [NUM_SPRITES*COLOR_W-1:0]                        spr_color,
    input  logic [COLOR_W-1:0]                                    bg_color,
    output logic [NUM_SPRITES*10-1:0]                             pos_x,
    output logic [NUM_SPRITES*10-1:0]                             pos_y,
    output logic [COLOR_W-1:0]                                    rgb,
    output logic                                                  collide
);
    localparam int ADDR_W = 2 * $clog2(SPRITE_SIZE);

    logic [NUM_SPRITES-1:0] hit_q;
    logic [NUM_SPRITES-1:0] opaque;
    logic                   act_q;
    logic [COLOR_W-1:0]     rgb_q, rgb_d, pick;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
        sprite_lane #(
            .LANE(i), .SPRITE_SIZE(SPRITE_SIZE), .SCREEN_W(SCREEN_W),
            .SCREEN_H(SCREEN_H), .STEP(STEP), .ADDR_W(ADDR_W)
        ) u_lane (
            .clk(clk), .reset(reset), .frame_end_i(frame_end), .pix_en_i(pix_en),
            .x_i(x), .y_i(y),
            .up_i(mv_up[i]), .down_i(mv_down[i]), .left_i(mv_left[i]), .right_i(mv_right[i]),
            .vis_i(spr_vis[i]),
            .pos_x_o(pos_x[i*10 +: 10]), .pos_y_o(pos_y[i*10 +: 10]),
            .hit_o(hit_q[i]), .addr_o(spr_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // Walk from the highest index down so the lowest-index opaque sprite wins.
    always_comb begin
        pick = bg_color;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            opaque[i] = hit_q[i] && (spr_color[i*COLOR_W +: COLOR_W] != TRANSPARENT_KEY);
            if (opaque[i]) pick = spr_color[i*COLOR_W +: COLOR_W];
        end
        rgb_d = act_q ? pick : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q <= 1'b0;
            rgb_q <= '0;
        end else if (pix_en) begin
            act_q <= active;
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

`ifdef SPRITE_COLLISION_EN
    logic multi, overlap_now, sticky_q, collide_q;

    // More than one bit set in opaque means at least two sprites overlap here.
    assign multi       = |(opaque & (opaque - 1'b1));
    assign overlap_now = pix_en && multi;

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q  <= 1'b0;
            collide_q <= 1'b0;
        end else if (frame_end) begin
            collide_q <= sticky_q | overlap_now;
            sticky_q  <= 1'b0;
        end else if (overlap_now) begin
            sticky_q  <= 1'b1;
        end
    end

    assign collide = collide_q;
`else
    assign collide = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a position/colour model predicts each pixel's rgb, checked one pix_en later.
// Collision expectations follow the SPRITE_COLLISION_EN build macro.
module tb_sprite_compositor;
    localparam logic [11:0] KEY = 12'hF0F;
`ifdef SPRITE_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef struct {
        logic [11:0] rgb;
        bit          ovl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, pix_en, active, frame_end;
    logic [9:0]  x, y;
    logic [1:0]  mv_up, mv_down, mv_left, mv_right, spr_vis;
    logic [23:0] spr_addr, spr_color;
    logic [11:0] bg_color, rgb;
    logic [19:0] pos_x, pos_y;
    logic        collide;

    int          n_checks = 0, n_errors = 0;
    int          mx[2], my[2];
    logic [11:0] col[2];
    bit          key[2];
    bit          sticky, exp_coll;
    exp_t        sb[$];

    always #5 clk = ~clk;

    assign spr_color = {key[1] ? KEY : col[1], key[0] ? KEY : col[0]};

    sprite_compositor dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .active(active), .frame_end(frame_end),
        .x(x), .y(y), .mv_up(mv_up), .mv_down(mv_down), .mv_left(mv_left), .mv_right(mv_right),
        .spr_vis(spr_vis), .spr_addr(spr_addr), .spr_color(spr_color), .bg_color(bg_color),
        .pos_x(pos_x), .pos_y(pos_y), .rgb(rgb), .collide(collide)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        mx[0] = 0;  my[0] = 0;
        mx[1] = 64; my[1] = 0;
        sticky = 0; exp_coll = 0;
        sb.delete();
        sb.push_back('{12'h000, 1'b0});
    endtask

    task automatic model_move(input logic [1:0] u, input logic [1:0] d,
                              input logic [1:0] l, input logic [1:0] r);
        for (int i = 0; i < 2; i++) begin
            if (r[i] && !l[i]) mx[i] = (mx[i] + 3 > 576) ? 576 : mx[i] + 3;
            else if (l[i] && !r[i]) mx[i] = (mx[i] < 3) ? 0 : mx[i] - 3;
            if (d[i] && !u[i]) my[i] = (my[i] + 3 > 416) ? 416 : my[i] + 3;
            else if (u[i] && !d[i]) my[i] = (my[i] < 3) ? 0 : my[i] - 3;
        end
    endtask

    task automatic model_pix(input int px, input int py, input bit act,
                             output exp_t e, output logic [23:0] ea);
        bit in;
        int nop;
        e.rgb = bg_color;
        e.ovl = 0;
        ea    = '0;
        nop   = 0;
        for (int i = 1; i >= 0; i--) begin
            in = spr_vis[i] && px >= mx[i] && px < mx[i] + 64 && py >= my[i] && py < my[i] + 64;
            if (in) ea[i*12 +: 12] = 12'((py - my[i]) * 64 + (px - mx[i]));
            if (in && !key[i]) begin
                nop++;
                e.rgb = col[i];
            end
        end
        if (!act) e.rgb = 12'h000;
        e.ovl = (nop >= 2);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pos_x"}, pos_x, {10'(mx[1]), 10'(mx[0])});
        chk({tag, "_pos_y"}, pos_y, {10'(my[1]), 10'(my[0])});
        chk({tag, "_collide"}, collide, COLL_EN ? exp_coll : 1'b0);
    endtask

    task automatic frames(input int n, input logic [1:0] u, input logic [1:0] d,
                          input logic [1:0] l, input logic [1:0] r);
        for (int k = 0; k < n; k++) begin
            mv_up = u; mv_down = d; mv_left = l; mv_right = r; frame_end = 1;
            @(posedge clk); #1;
            frame_end = 0; mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0;
            model_move(u, d, l, r);
            exp_coll = sticky;
            sticky   = 0;
        end
        chk_state("frame");
    endtask

    task automatic pixel(input int px, input int py, input bit act,
                         input bit fe = 0, input logic [1:0] mr = 2'b00);
        exp_t        e, prev;
        logic [23:0] ea;
        model_pix(px, py, act, e, ea);
        x = 10'(px); y = 10'(py); active = act; pix_en = 1; frame_end = fe; mv_right = mr;
        @(posedge clk); #1;
        pix_en = 0; frame_end = 0; mv_right = 0;
        prev.ovl = 0;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_underflow: got empty expected entry at (%0d,%0d)", px, py);
        end else begin
            prev = sb.pop_front();
            chk($sformatf("rgb_before_%0d_%0d", px, py), rgb, prev.rgb);
        end
        chk($sformatf("spr_addr_%0d_%0d", px, py), spr_addr, ea);
        if (fe) begin
            exp_coll = sticky | prev.ovl;
            sticky   = 0;
            model_move(2'b00, 2'b00, 2'b00, mr);
            chk_state("pix_frame");
        end else begin
            sticky |= prev.ovl;
        end
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; pix_en = 0; active = 0; frame_end = 0; x = 0; y = 0;
        mv_up = 0; mv_down = 0; mv_left = 0; mv_right = 0; spr_vis = 2'b11;
        col[0] = 12'h0F0; col[1] = 12'h00F; key[0] = 0; key[1] = 0; bg_color = 12'h123;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_reset();
        chk_state("reset");
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_addr", spr_addr, 24'h0);

        frames(200, 2'b00, 2'b00, 2'b00, 2'b01);
        chk("right200_x0", pos_x[9:0], 10'd576);
        chk("right200_y0", pos_y[9:0], 10'd0);
        frames(5, 2'b00, 2'b00, 2'b10, 2'b10);
        chk("lr_hold_x1", pos_x[19:10], 10'd64);
        frames(200, 2'b00, 2'b01, 2'b00, 2'b00);
        chk("down_clamp_y0", pos_y[9:0], 10'd416);
        frames(2, 2'b01, 2'b01, 2'b00, 2'b00);
        frames(200, 2'b01, 2'b00, 2'b01, 2'b00);
        // STEP=3 cannot reach (100,100) from the reset grid, so both sprites meet at (99,99).
        frames(22, 2'b00, 2'b00, 2'b10, 2'b00);
        chk("left_clamp_x1", pos_x[19:10], 10'd0);
        frames(33, 2'b00, 2'b11, 2'b00, 2'b11);

        pixel(99, 99, 1);
        pixel(100, 100, 1);
        pixel(98, 99, 1);
        pixel(162, 162, 1);
        pixel(163, 100, 1);
        pixel(100, 163, 1);
        pixel(100, 100, 0);
        pixel(0, 0, 0);
        frames(1, 2'b00, 2'b00, 2'b00, 2'b00);

        key[0] = 1;
        pixel(100, 100, 1);
        spr_vis = 2'b01;
        pixel(100, 100, 1);
        pixel(0, 0, 0);
        key[1] = 1; spr_vis = 2'b11;
        pixel(100, 100, 1);
        pixel(0, 0, 0);
        key[0] = 0; key[1] = 0; spr_vis = 2'b10;
        pixel(120, 120, 1);
        spr_vis = 2'b11;
        pixel(0, 0, 0);
        frames(1, 2'b00, 2'b00, 2'b00, 2'b00);

        pixel(99, 99, 1, 1'b1, 2'b01);
        pixel(99, 99, 1);
        pixel(130, 130, 1);
        pixel(0, 0, 0);
        frames(1, 2'b00, 2'b00, 2'b00, 2'b01);
        frames(199, 2'b00, 2'b00, 2'b00, 2'b01);
        pixel(120, 120, 1);
        pixel(0, 0, 0);
        frames(1, 2'b00, 2'b00, 2'b00, 2'b00);

        pixel(120, 120, 1);
        x = 10'd121; y = 10'd120; active = 1; pix_en = 1; frame_end = 1; mv_right = 2'b11; reset = 1;
        @(posedge clk); #1;
        reset = 0; pix_en = 0; frame_end = 0; mv_right = 0;
        model_reset();
        chk("midreset_pos_x", pos_x, {10'd64, 10'd0});
        chk("midreset_pos_y", pos_y, 20'd0);
        chk("midreset_rgb", rgb, 12'h000);
        chk("midreset_addr", spr_addr, 24'h0);
        chk("midreset_collide", collide, 1'b0);
        @(posedge clk); #1;
        pixel(10, 10, 1);
        pixel(70, 5, 1);
        pixel(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 2: number of independently movable sprites, range 1..8.
REQ-002 SHALL have parameter SPRITE_SIZE, default 64: square sprite edge in pixels, power of two.
REQ-003 SHALL have parameters SCREEN_W, default 640, and SCREEN_H, default 480: visible area.
REQ-004 SHALL have parameter STEP, default 3: pixels moved per frame per asserted direction.
REQ-005 SHALL have parameter COLOR_W, default 12: RGB width.
REQ-006 SHALL have parameter TRANSPARENT_KEY, default 12'hF0F: sprite colour treated as see-through.
REQ-007 SHALL have one clock and a synchronous, active-high reset.
REQ-008 Port: clk  input  1  system clock (100 MHz).
REQ-009 Port: reset  input  1  synchronous, active-high reset.
REQ-010 Port: pix_en  input  1  one-clk pixel-tick strobe, period of at least 2 clk.
REQ-011 Port: active, frame_end  input  1 each  timing-generator visible flag; one-clk end-of-frame pulse.
REQ-012 Port: x, y  input  10 each  current pixel coordinate.
REQ-013 Port: mv_up, mv_down, mv_left, mv_right  input  NUM_SPRITES each  per-sprite direction requests.
REQ-014 Port: spr_vis  input  NUM_SPRITES  per-sprite visibility enable.
REQ-015 Port: spr_addr  output  NUM_SPRITES*log2(SPRITE_SIZE^2)  per-sprite ROM address.
REQ-016 Port: spr_color  input  NUM_SPRITES*COLOR_W  per-sprite ROM data.
REQ-017 Port: bg_color  input  COLOR_W  background colour for the same pixel.
REQ-018 Port: pos_x, pos_y  output  NUM_SPRITES*10 each  sprite top-left positions.
REQ-019 Port: rgb  output  COLOR_W  composited pixel colour.
REQ-020 Port: collide  output  1  previous frame contained a sprite overlap.

Function
REQ-021 SHALL update positions only on the clk where frame_end=1.
REQ-022 Per axis: SHALL hold the position when both directions are asserted; otherwise SHALL move by STEP in the requested direction.
REQ-023 Clamping: x SHALL saturate to 0..SCREEN_W-SPRITE_SIZE and y to 0..SCREEN_H-SPRITE_SIZE; no wrap-around.
REQ-024 Hit test: SHALL compute hit[i] = spr_vis[i] && x in [pos_x_i, pos_x_i+SPRITE_SIZE) && y in [pos_y_i, pos_y_i+SPRITE_SIZE), using 11-bit unsigned arithmetic.
REQ-025 Stage 1, on pix_en: SHALL register hit, active and spr_addr_i = (y-pos_y_i)*SPRITE_SIZE + (x-pos_x_i).
REQ-026 spr_addr_i SHALL be 0 when hit[i]=0.
REQ-027 Stage 2, on the next pix_en: SHALL sample spr_color and bg_color, then register rgb.
REQ-028 Total latency SHALL be 1 pix_en tick from the x/y sample.
REQ-029 A sprite SHALL be opaque when its registered hit is 1 and its colour is not TRANSPARENT_KEY.
REQ-030 rgb SHALL be 0 when registered active=0.
REQ-031 Otherwise rgb SHALL be the colour of the lowest-index opaque sprite, or bg_color when no sprite is opaque.
REQ-032 When frame_end and pix_en coincide, the pipeline SHALL advance with the old positions; new positions SHALL apply from the next pix_en.
REQ-033 Without pix_en, all pipeline registers SHALL hold their values.

Reset
REQ-034 On reset: pos_x_i SHALL be i*SPRITE_SIZE and pos_y_i SHALL be 0.
REQ-035 On reset: rgb, collide, spr_addr, the collision flag and the stage-1 hit/active registers SHALL be 0.
REQ-036 Reset SHALL override frame_end and pix_en in the same cycle.
REQ-037 After a reset mid-frame, the first pix_en SHALL produce rgb=0.

Configuration
REQ-038 Macro SPRITE_COLLISION_EN SHALL control collision detection.
REQ-039 When defined: a sticky flag SHALL set on any stage-2 pixel with two or more opaque sprites.
REQ-040 When defined: on frame_end, collide SHALL load (sticky OR the current-cycle overlap) and sticky SHALL clear.
REQ-041 When undefined: collide SHALL be constant 0 and no collision logic SHALL be synthesised.

Verification
REQ-042 Reset, then hold mv_right[0] for 200 frames -> pos_x_0 = 576 (clamped, since 200*3 = 600 > 576); pos_y_0 = 0.
REQ-043 mv_left[1] and mv_right[1] both asserted for 5 frames -> pos_x_1 stays 64.
REQ-044 Sprites 0 and 1 both at (100,100), both opaque colour 12'h0F0/12'h00F -> rgb = 12'h0F0 one pix_en after x=y=100.
REQ-045 Same pixel with sprite 0 colour = 12'hF0F -> rgb = 12'h00F.
REQ-046 With SPRITE_COLLISION_EN, run the REQ-044 frame -> collide = 1 after frame_end; run the next frame with sprites apart -> collide = 0.
REQ-047 Assert reset for one clk mid-line with active=1 -> positions return to (0,0) and (64,0), and the next rgb = 0.
